// File: rtl/l2_port_arbiter_if.sv
// Bundle of requester, L2 and status signals around the shared L2 port arbiter.
// The arbiter takes the slave view; the requesters and L2 model take the master view.
interface l2_port_arbiter_if;
  logic         i_req;
  logic [63:0]  i_addr;
  logic         d_req;
  logic         d_we;
  logic [63:0]  d_addr;
  logic [63:0]  d_wdata;
  logic [2:0]   d_wsize;
  logic         d_clf;

  logic         i_done;
  logic [127:0] i_data;
  logic         d_done;
  logic [127:0] d_data;

  logic         l2_enable;
  logic         l2_we;
  logic [63:0]  l2_addr;
  logic [63:0]  l2_wdata;
  logic [2:0]   l2_wsize;
  logic         l2_clf;
  logic         l2_done;
  logic [127:0] l2_data;

  logic         busy;
  logic         owner;
  logic         timeout_err;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_wsize, d_clf,
    input  l2_done, l2_data,
    output i_done, i_data, d_done, d_data,
    output l2_enable, l2_we, l2_addr, l2_wdata, l2_wsize, l2_clf,
    output busy, owner, timeout_err
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_wsize, d_clf,
    output l2_done, l2_data,
    input  i_done, i_data, d_done, d_data,
    input  l2_enable, l2_we, l2_addr, l2_wdata, l2_wsize, l2_clf,
    input  busy, owner, timeout_err
  );
endinterface

// File: rtl/l2_port_arbiter.sv
// Round-robin arbiter sharing one L2 request port between the I-side and D-side
// miss paths, with a WAIT-state watchdog that aborts hung L2 transactions.
//
// state    | meaning
// IDLE     | no transaction; sample requests and grant one
// WAIT     | l2_enable high, command held, waiting for l2_done or watchdog expiry
// RESPOND  | one-cycle done pulse with captured line to the owner
module l2_port_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned CNT_W          = 16
) (
  input  logic              clk,
  input  logic              reset,
  l2_port_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_RESPOND = 2'd2
  } state_e;

  localparam bit WD_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] WD_LAST =
    (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_d;
  logic               last_owner_q;
  logic               owner_q;

  logic               l2_enable_q;
  logic               l2_we_q;
  logic [63:0]        l2_addr_q;
  logic [63:0]        l2_wdata_q;
  logic [2:0]         l2_wsize_q;
  logic               l2_clf_q;

  logic               i_done_q;
  logic [127:0]       i_data_q;
  logic               d_done_q;
  logic [127:0]       d_data_q;
  logic               busy_q;
  logic               timeout_err_q;

  logic               any_req;
  logic               grant_d;
  logic               wd_expire;
  logic [127:0]       resp_data;

  // On a tie the side opposite last_owner wins; a lone request always wins.
  assign any_req   = bus.i_req | bus.d_req;
  assign grant_d   = bus.d_req & (~bus.i_req | ~last_owner_q);
  assign wd_expire = WD_EN && (cnt_q == WD_LAST);
  assign resp_data = bus.l2_done ? bus.l2_data : '0;
  assign cnt_d     = cnt_q + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      last_owner_q  <= 1'b1;
      owner_q       <= 1'b0;
      l2_enable_q   <= 1'b0;
      l2_we_q       <= 1'b0;
      l2_addr_q     <= '0;
      l2_wdata_q    <= '0;
      l2_wsize_q    <= '0;
      l2_clf_q      <= 1'b0;
      i_done_q      <= 1'b0;
      i_data_q      <= '0;
      d_done_q      <= 1'b0;
      d_data_q      <= '0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (any_req) begin
            state_q     <= S_WAIT;
            cnt_q       <= '0;
            l2_enable_q <= 1'b1;
            busy_q      <= 1'b1;
            owner_q     <= grant_d;
            if (grant_d) begin
              l2_we_q    <= bus.d_we;
              l2_addr_q  <= bus.d_addr;
              l2_wdata_q <= bus.d_wdata;
              l2_wsize_q <= bus.d_wsize;
              l2_clf_q   <= bus.d_clf;
            end else begin
              l2_we_q    <= 1'b0;
              l2_addr_q  <= bus.i_addr;
              l2_wdata_q <= '0;
              l2_wsize_q <= '0;
              l2_clf_q   <= 1'b0;
            end
          end
        end

        S_WAIT: begin
          // l2_done beats a same-edge watchdog expiry.
          if (bus.l2_done || wd_expire) begin
            state_q     <= S_RESPOND;
            l2_enable_q <= 1'b0;
            if (owner_q) begin
              d_done_q <= 1'b1;
              d_data_q <= resp_data;
            end else begin
              i_done_q <= 1'b1;
              i_data_q <= resp_data;
            end
            if (!bus.l2_done) begin
              timeout_err_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_d;
          end
        end

        S_RESPOND: begin
          state_q      <= S_IDLE;
          i_done_q     <= 1'b0;
          i_data_q     <= '0;
          d_done_q     <= 1'b0;
          d_data_q     <= '0;
          busy_q       <= 1'b0;
          last_owner_q <= owner_q;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.i_done      = i_done_q;
  assign bus.i_data      = i_data_q;
  assign bus.d_done      = d_done_q;
  assign bus.d_data      = d_data_q;
  assign bus.l2_enable   = l2_enable_q;
  assign bus.l2_we       = l2_we_q;
  assign bus.l2_addr     = l2_addr_q;
  assign bus.l2_wdata    = l2_wdata_q;
  assign bus.l2_wsize    = l2_wsize_q;
  assign bus.l2_clf      = l2_clf_q;
  assign bus.busy        = busy_q;
  assign bus.owner       = owner_q;
  assign bus.timeout_err = timeout_err_q;

endmodule

// File: tb/tb_l2_port_arbiter.sv
// Directed bench for l2_port_arbiter: one task per scenario, inline expected values.
module tb_l2_port_arbiter;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  l2_port_arbiter_if bus ();

  l2_port_arbiter #(
    .TIMEOUT_CYCLES(4),
    .CNT_W(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL sim_timeout got=running exp=finished");
    $fatal(1, "simulation time limit");
  end

  // {l2_enable, busy, owner, i_done, d_done, timeout_err}
  function automatic logic [5:0] status();
    return {bus.l2_enable, bus.busy, bus.owner, bus.i_done, bus.d_done, bus.timeout_err};
  endfunction

  function automatic logic [394:0] all_out();
    return {bus.i_done, bus.i_data, bus.d_done, bus.d_data, bus.l2_enable, bus.l2_we,
            bus.l2_addr, bus.l2_wdata, bus.l2_wsize, bus.l2_clf, bus.busy, bus.owner,
            bus.timeout_err};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.i_req   = 1'b0;
    bus.i_addr  = '0;
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
    bus.d_addr  = '0;
    bus.d_wdata = '0;
    bus.d_wsize = '0;
    bus.d_clf   = 1'b0;
    bus.l2_done = 1'b0;
    bus.l2_data = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    total++;
    if (all_out() !== '0) begin
      bad++;
      $display("FAIL reset_outputs got=%0h exp=0", all_out());
    end
    tick();
    total++;
    if (all_out() !== '0) begin
      bad++;
      $display("FAIL reset_idle_outputs got=%0h exp=0", all_out());
    end
  endtask

  task automatic test_d_write();
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_addr  = 64'd16384;
    bus.d_wdata = 64'd8;
    bus.d_wsize = 3'd3;
    bus.l2_data = 128'h55;
    tick();
    total++;
    if ({bus.l2_we, bus.l2_addr, bus.l2_wdata, bus.l2_wsize} !== {1'b1, 64'd16384, 64'd8, 3'd3}) begin
      bad++;
      $display("FAIL dw_cmd got=%0h/%0d/%0d/%0d exp=1/16384/8/3",
               bus.l2_we, bus.l2_addr, bus.l2_wdata, bus.l2_wsize);
    end
    total++;
    if (status() !== 6'b111000) begin
      bad++;
      $display("FAIL dw_wait1_status got=%b exp=111000", status());
    end
    tick();
    total++;
    if (status() !== 6'b111000) begin
      bad++;
      $display("FAIL dw_wait2_status got=%b exp=111000", status());
    end
    bus.l2_done = 1'b1;
    tick();
    total++;
    if (status() !== 6'b011010) begin
      bad++;
      $display("FAIL dw_respond_status got=%b exp=011010", status());
    end
    total++;
    if ({bus.d_data, bus.i_data} !== {128'h55, 128'h0}) begin
      bad++;
      $display("FAIL dw_respond_data got=%0h/%0h exp=55/0", bus.d_data, bus.i_data);
    end
    bus.l2_done = 1'b0;
    bus.d_req   = 1'b0;
    tick();
    total++;
    if ({status(), bus.d_data} !== {6'b001000, 128'h0}) begin
      bad++;
      $display("FAIL dw_idle got=%b/%0h exp=001000/0", status(), bus.d_data);
    end
  endtask

  task automatic test_i_read();
    idle_inputs();
    bus.i_req  = 1'b1;
    bus.i_addr = 64'd4096;
    bus.d_we    = 1'b1;
    bus.d_wdata = 64'hFFFF;
    bus.d_wsize = 3'd7;
    bus.d_clf   = 1'b1;
    tick();
    total++;
    if ({bus.l2_we, bus.l2_addr, bus.l2_wdata, bus.l2_wsize, bus.l2_clf} !== {1'b0, 64'd4096, 64'd0, 3'd0, 1'b0}) begin
      bad++;
      $display("FAIL ir_cmd got=%0h/%0d/%0h/%0d/%0h exp=0/4096/0/0/0",
               bus.l2_we, bus.l2_addr, bus.l2_wdata, bus.l2_wsize, bus.l2_clf);
    end
    total++;
    if (status() !== 6'b110000) begin
      bad++;
      $display("FAIL ir_wait_status got=%b exp=110000", status());
    end
    bus.l2_done = 1'b1;
    bus.l2_data = 128'hDEAD_BEEF;
    tick();
    total++;
    if ({status(), bus.i_data, bus.d_data} !== {6'b010100, 128'hDEAD_BEEF, 128'h0}) begin
      bad++;
      $display("FAIL ir_respond got=%b/%0h/%0h exp=010100/deadbeef/0", status(), bus.i_data, bus.d_data);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_contention();
    logic [4:0]  exp_tbl [8];
    logic [63:0] exp_addr;
    exp_tbl = '{5'b11000, 5'b01010, 5'b00000, 5'b11100,
                5'b01101, 5'b00100, 5'b11000, 5'b01010};
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.i_req   = 1'b1;
    bus.i_addr  = 64'h100;
    bus.d_req   = 1'b1;
    bus.d_addr  = 64'h200;
    bus.l2_done = 1'b1;
    bus.l2_data = 128'h1234;
    for (int c = 0; c < 8; c++) begin
      tick();
      total++;
      if (status()[5:1] !== exp_tbl[c]) begin
        bad++;
        $display("FAIL cont_cycle%0d got=%b exp=%b", c, status()[5:1], exp_tbl[c]);
      end
      if (c == 0 || c == 3 || c == 6) begin
        exp_addr = (c == 3) ? 64'h200 : 64'h100;
        total++;
        if (bus.l2_addr !== exp_addr) begin
          bad++;
          $display("FAIL cont_addr%0d got=%0h exp=%0h", c, bus.l2_addr, exp_addr);
        end
      end
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_watchdog();
    idle_inputs();
    bus.d_req   = 1'b1;
    bus.d_addr  = 64'h4000;
    bus.l2_data = 128'hABCD;
    for (int c = 0; c < 4; c++) begin
      tick();
      total++;
      if (status() !== 6'b111000) begin
        bad++;
        $display("FAIL wd_wait%0d got=%b exp=111000", c, status());
      end
    end
    tick();
    total++;
    if ({status(), bus.d_data} !== {6'b011011, 128'h0}) begin
      bad++;
      $display("FAIL wd_abort got=%b/%0h exp=011011/0", status(), bus.d_data);
    end
    bus.d_req = 1'b0;
    tick();
    total++;
    if (status() !== 6'b001001) begin
      bad++;
      $display("FAIL wd_sticky got=%b exp=001001", status());
    end
  endtask

  task automatic test_reset_mid_wait();
    idle_inputs();
    bus.d_req  = 1'b1;
    bus.d_addr = 64'h8000;
    tick();
    total++;
    if (status() !== 6'b111001) begin
      bad++;
      $display("FAIL rmw_wait got=%b exp=111001", status());
    end
    tick();
    reset     = 1'b1;
    bus.d_req = 1'b0;
    tick();
    reset = 1'b0;
    total++;
    if (all_out() !== '0) begin
      bad++;
      $display("FAIL rmw_after_reset got=%0h exp=0", all_out());
    end
    bus.l2_done = 1'b1;
    bus.l2_data = 128'h77;
    for (int c = 0; c < 2; c++) begin
      tick();
      total++;
      if (all_out() !== '0) begin
        bad++;
        $display("FAIL rmw_late_done%0d got=%0h exp=0", c, all_out());
      end
    end
    bus.l2_done = 1'b0;
    bus.i_req   = 1'b1;
    bus.i_addr  = 64'h40;
    bus.d_req   = 1'b1;
    bus.d_addr  = 64'h80;
    tick();
    total++;
    if ({status(), bus.l2_addr} !== {6'b110000, 64'h40}) begin
      bad++;
      $display("FAIL rmw_regrant got=%b/%0h exp=110000/40", status(), bus.l2_addr);
    end
    bus.l2_done = 1'b1;
    tick();
    total++;
    if ({status(), bus.i_data} !== {6'b010100, 128'h77}) begin
      bad++;
      $display("FAIL rmw_regrant_done got=%b/%0h exp=010100/77", status(), bus.i_data);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_input_stability();
    idle_inputs();
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_addr  = 64'd16384;
    bus.d_wdata = 64'd8;
    tick();
    bus.d_addr  = 64'd30000;
    bus.d_wdata = 64'd99;
    bus.d_we    = 1'b0;
    bus.i_req   = 1'b1;
    bus.i_addr  = 64'd5;
    tick();
    total++;
    if ({status(), bus.l2_addr, bus.l2_wdata, bus.l2_we} !== {6'b111000, 64'd16384, 64'd8, 1'b1}) begin
      bad++;
      $display("FAIL stab_hold got=%b/%0d/%0d/%0h exp=111000/16384/8/1",
               status(), bus.l2_addr, bus.l2_wdata, bus.l2_we);
    end
    bus.l2_done = 1'b1;
    bus.l2_data = 128'h99;
    tick();
    total++;
    if ({status(), bus.d_data} !== {6'b011010, 128'h99}) begin
      bad++;
      $display("FAIL stab_done got=%b/%0h exp=011010/99", status(), bus.d_data);
    end
    bus.d_req = 1'b0;
    bus.i_req = 1'b0;
    tick();
    for (int c = 0; c < 2; c++) begin
      tick();
      total++;
      if ({status(), bus.i_data, bus.d_data} !== {6'b001000, 128'h0, 128'h0}) begin
        bad++;
        $display("FAIL stab_spurious%0d got=%b exp=001000", c, status());
      end
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_d_write();
    test_i_read();
    test_contention();
    test_watchdog();
    test_reset_mid_wait();
    test_input_stability();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/l2_port_arbiter.md
Name: l2_port_arbiter

Overview:
Arbitrates the single shared L2 request port between the L1 instruction cache miss path (I-side) and the L1 data cache miss/writeback path (D-side).
- Latches one requester's command, drives it to L2 with a level enable, and waits for L2 completion.
- Returns the 128-bit line and a one-cycle done pulse to the granted requester.
- Round-robin on contention; a watchdog aborts hung L2 transactions.

Parameters:
TIMEOUT_CYCLES, 64, WAIT-state cycles before abort; 0 disables the watchdog.
CNT_W, 16, width of the watchdog counter; must satisfy TIMEOUT_CYCLES < 2^CNT_W.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  synchronous, active-high reset.
i_req  input  1  I-side miss request; held high until i_done.
i_addr  input  64  I-side read address.
d_req  input  1  D-side request; held high until d_done.
d_we  input  1  D-side write enable (1 = write, 0 = read).
d_addr  input  64  D-side address.
d_wdata  input  64  D-side write data.
d_wsize  input  3  D-side write size code.
d_clf  input  1  D-side cache line flush.
i_done  output  1  one-cycle completion pulse to I-side.
i_data  output  128  line returned to I-side; valid only while i_done=1.
d_done  output  1  one-cycle completion pulse to D-side.
d_data  output  128  line returned to D-side; valid only while d_done=1.
l2_enable  output  1  level request to L2; high for the whole transaction.
l2_we  output  1  forwarded write enable.
l2_addr  output  64  forwarded address.
l2_wdata  output  64  forwarded write data.
l2_wsize  output  3  forwarded write size.
l2_clf  output  1  forwarded CLF.
l2_done  input  1  L2 completion; sampled only in WAIT.
l2_data  input  128  L2 read data; valid with l2_done.
busy  output  1  high in WAIT and RESPOND.
owner  output  1  current or last grant (0 = I, 1 = D).
timeout_err  output  1  sticky; set on any watchdog abort.

Behaviour:
- All outputs are registered.
- Reset values: every output is 0. Internal state: state=IDLE, last_owner=1, so I-side wins the first tie.
- Reset asserted mid-transaction aborts it: no done pulse, and l2_enable is low the cycle after the reset edge.
- State machine:
  - IDLE → WAIT when i_req or d_req is sampled high.
  - WAIT → RESPOND on l2_done=1, or on watchdog expiry.
  - RESPOND → IDLE unconditionally after one cycle.
- IDLE grant rules:
  - Only one request: grant it.
  - Both requests: grant the side opposite last_owner.
  - On grant, latch the command into the l2_* registers and set owner.
  - I-side grant forces l2_we=0, l2_wdata=0, l2_wsize=0, l2_clf=0.
- WAIT:
  - l2_enable=1 and the l2_* fields are held stable; later requester input changes are ignored.
  - Watchdog counter starts at 0 on entry and increments every WAIT cycle.
  - l2_done=1 at an edge: capture l2_data, go to RESPOND.
  - If TIMEOUT_CYCLES≠0 and the counter reaches TIMEOUT_CYCLES-1 without l2_done: go to RESPOND with data=0 and set timeout_err.
  - l2_done and expiry on the same edge: l2_done wins, data is captured, timeout_err is not set.
- RESPOND:
  - l2_enable=0; the owner's done=1 with the captured data; the other side's done=0 and its data=0.
  - last_owner is updated to owner.
- Requester rule: deassert req at the edge that samples done=1. The arbiter does not sample requests in RESPOND.
- Latency: the cycle after req is sampled, l2_enable=1. If l2_done is sampled at the first WAIT edge, done=1 on the next cycle, i.e. 2 cycles after the req sample edge. Back-to-back transactions have 1 idle cycle.
- l2_done outside WAIT is ignored.
- Data is passed through unmodified; no width arithmetic is performed.

Test Plan:
- Single D write: d_req=1, d_we=1, d_addr=16384, d_wdata=8, d_wsize=3; L2 gives l2_done after 2 WAIT cycles → l2_enable high 2 cycles with l2_addr=16384 and l2_wdata=8, then d_done=1 one cycle, owner=1, i_done stays 0.
- Single I read: i_addr=4096; l2_data=128'hDEAD_BEEF on l2_done → i_done=1, i_data=128'hDEAD_BEEF, l2_we=0.
- Contention from reset: i_req and d_req both high, both held, 3 transactions → grant order I, D, I; owner toggles 0,1,0; one idle cycle between transactions.
- Watchdog: TIMEOUT_CYCLES=4, l2_done never asserted → l2_enable high exactly 4 cycles, then d_done=1 with d_data=0 and timeout_err=1, which stays 1 until reset.
- Reset mid-WAIT: assert reset during the 2nd WAIT cycle → next cycle all outputs 0 and no done pulse; a later l2_done is ignored; a new i_req is then granted I-first.
- Input stability: change d_addr from 16384 to 30000 during WAIT → l2_addr stays 16384; a spurious l2_done in IDLE causes no state change.
